// File: rtl/tipi_rpi_shifter.sv
// Byte-wide register shifter between a host and the TIPI TI-side latch chain.
// Optional macro TIPI_SHIFTER_DIN_SYNC_EN adds a 2-flop synchronizer on r_din (requires CLK_DIV >= 3).
module tipi_rpi_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       op_write,
  input  logic       sel_ctrl,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       r_clk,
  output logic       r_le,
  output logic       r_dc,
  output logic       r_rt,
  output logic       r_dout,
  input  logic       r_din
);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, LOW, HIGH, LATCH, DONE} state_t;

  localparam logic [7:0] TICK_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] tick;
  logic [2:0] bit_cnt;
  logic [2:0] bit_nxt;
  logic       wr_q;
  logic [7:0] wdata_q;
  logic [7:0] rx_sh;
  logic       din_s;
  logic       tick_end;

  assign tick_end = (tick == TICK_LAST);
  assign bit_nxt  = bit_cnt + 3'd1;

`ifdef TIPI_SHIFTER_DIN_SYNC_EN
  logic [1:0] din_sync;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) din_sync <= 2'b00;
    else          din_sync <= {din_sync[0], r_din};
  end
  assign din_s = din_sync[1];
`else
  assign din_s = r_din;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tick    <= 8'd0;
      bit_cnt <= 3'd0;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      rx_sh   <= 8'h00;
      rdata   <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      r_clk   <= 1'b0;
      r_le    <= 1'b0;
      r_dc    <= 1'b0;
      r_rt    <= 1'b0;
      r_dout  <= 1'b0;
    end else begin
      // Every timed state runs T cycles; the counter wraps on the state boundary.
      if (state != IDLE && state != DONE)
        tick <= tick_end ? 8'd0 : tick + 8'd1;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= SETUP;
            busy    <= 1'b1;
            wr_q    <= op_write;
            wdata_q <= wdata;
            r_rt    <= ~op_write;
            r_dc    <= sel_ctrl;
            r_clk   <= 1'b0;
            r_le    <= 1'b0;
            if (op_write) r_dout <= wdata[7];
            tick    <= 8'd0;
            bit_cnt <= 3'd0;
          end
        end
        SETUP: begin
          if (tick_end) begin
            if (wr_q) begin
              state <= LOW;
            end else begin
              state <= LOAD;
              r_le  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (tick_end) begin
            state <= LOW;
            r_le  <= 1'b0;
          end
        end
        LOW: begin
          if (tick_end) begin
            state <= HIGH;
            r_clk <= 1'b1;
            // Bit i lands in position 7-i, i.e. MSB first.
            if (!wr_q) rx_sh[~bit_cnt] <= din_s;
          end
        end
        HIGH: begin
          if (tick_end) begin
            r_clk <= 1'b0;
            if (bit_cnt == 3'd7) begin
              if (wr_q) begin
                state <= LATCH;
                r_le  <= 1'b1;
              end else begin
                state <= DONE;
                done  <= 1'b1;
                rdata <= rx_sh;
              end
            end else begin
              state   <= LOW;
              bit_cnt <= bit_nxt;
              if (wr_q) r_dout <= wdata_q[~bit_nxt];
            end
          end
        end
        LATCH: begin
          if (tick_end) begin
            state <= DONE;
            r_le  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          bit_cnt <= 3'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tipi_rpi_shifter.md
TIPI_RPI_SHIFTER -- requirements
Module: tipi_rpi_shifter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per r_clk half-period (T), legal range 1..255.
REQ-002 SHALL have one clock and an asynchronous active-low reset.
REQ-003 SHALL have ports in this order:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- start  in  1  request one register transfer
- op_write  in  1  1 = write RD/RC, 0 = read TD/TC
- sel_ctrl  in  1  0 = data register, 1 = control register
- wdata  in  8  byte to write
- rdata  out  8  byte read
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- r_clk  out  1  serial shift clock
- r_le  out  1  load/latch enable
- r_dc  out  1  0 = data, 1 = control
- r_rt  out  1  0 = RPi-originated (RD/RC), 1 = TI-originated (TD/TC)
- r_dout  out  1  serial data to TI side
- r_din  in  1  serial data from TI side

Function
REQ-004 SHALL implement FSM states IDLE, SETUP, LOAD, LOW, HIGH, LATCH, DONE; every state except IDLE and DONE SHALL last exactly T clk cycles, timed by an internal tick counter.
REQ-005 In IDLE with start=1 (cycle 0), SHALL capture op_write, sel_ctrl and wdata, and enter SETUP in cycle 1; busy SHALL be 1 from cycle 1 through the DONE cycle.
REQ-006 SETUP SHALL drive r_rt=~op_write, r_dc=sel_ctrl, r_clk=0, r_le=0; on writes it SHALL also drive r_dout=wdata[7].
REQ-007 For reads, SETUP SHALL be followed by LOAD, with r_le=1 and r_clk=0, and then by 8 LOW/HIGH pairs.
REQ-008 For writes, SETUP SHALL be followed directly by 8 LOW/HIGH pairs and then by LATCH, with r_le=1 and r_clk=0.
REQ-009 LOW SHALL drive r_clk=0; HIGH SHALL drive r_clk=1; a 3-bit bit counter SHALL index pair i = 0..7.
REQ-010 Writes SHALL send MSB first: in LOW and HIGH of pair i, r_dout = captured wdata[7-i], held stable across the r_clk rising edge.
REQ-011 Reads SHALL sample r_din in the last cycle of LOW of pair i into shift bit 7-i (MSB first); rdata SHALL update only in the DONE cycle.
REQ-012 DONE SHALL last one cycle with done=1 and then return to IDLE; done SHALL occur in cycle 18T+1 for both reads and writes.
REQ-013 r_le SHALL pulse exactly once per transfer and never while r_clk=1.
REQ-014 r_clk SHALL have exactly 8 rising edges per transfer.
REQ-015 start SHALL be ignored while busy=1 or in DONE; changes to inputs after cycle 0 SHALL NOT affect the transfer.
REQ-016 In IDLE, r_clk=0 and r_le=0; r_rt, r_dc and r_dout SHALL hold their last driven values.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 While reset_n=0, outputs SHALL immediately be: r_clk=0, r_le=0, r_rt=0, r_dc=0, r_dout=0, busy=0, done=0, rdata=0x00; the FSM SHALL be in IDLE and all counters 0.
REQ-019 Reset mid-transfer SHALL abort it with no done pulse; the first start after release SHALL complete normally.

Configuration
REQ-020 With macro TIPI_SHIFTER_DIN_SYNC_EN defined, r_din SHALL pass through a 2-flop synchronizer before sampling, and sampling SHALL use the synchronized value; CLK_DIV SHALL be at least 3, and the sample point and latency SHALL be unchanged.
REQ-021 Without TIPI_SHIFTER_DIN_SYNC_EN, r_din SHALL be sampled directly and CLK_DIV=1 SHALL be legal.

Verification
REQ-022 Reset asserted mid-read -> all outputs at reset values within the same cycle; busy=0; no done pulse.
REQ-023 CLK_DIV=2, write RD with wdata=0xA5 -> r_rt=0, r_dc=0; r_dout at the 8 r_clk rising edges = 1,0,1,0,0,1,0,1; one r_le pulse after the last edge; done in cycle 37.
REQ-024 CLK_DIV=2, read TC with the TI model shifting 0x3C MSB first after the r_le load -> r_rt=1, r_dc=1; r_le pulse before the first r_clk; rdata=0x3C with done in cycle 37.
REQ-025 start re-asserted and wdata changed to 0xFF during a 0x12 write -> second start ignored; shifted bits = 0x12; exactly one done.
REQ-026 Back-to-back read TD then write RC, with start asserted in the DONE cycle of the first -> second start ignored; second transfer begins only after re-assertion in IDLE.
REQ-027 TIPI_SHIFTER_DIN_SYNC_EN defined, CLK_DIV=3, read TD=0x81 -> rdata=0x81; done in cycle 55.
